// File: rtl/board_controller.sv
// Tic-tac-toe board controller: synchronized switch rises place X/O marks.
// Optional WIN_MASK_EN adds a win_mask output marking tiles on winning lines.
module board_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  input_switches,
  output logic [17:0] tiles,
  output logic        turn,
  output logic [1:0]  winner,
  output logic        game_over,
  output logic [3:0]  move_count,
  output logic        move_ok,
  output logic        move_err
`ifdef WIN_MASK_EN
  ,
  output logic [8:0]  win_mask
`endif
);

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    OVER  = 2'd2
  } state_t;

  localparam logic [8:0] LINE_MASK [8] = '{
    9'b000_000_111, 9'b000_111_000, 9'b111_000_000,
    9'b001_001_001, 9'b010_010_010, 9'b100_100_100,
    9'b100_010_001, 9'b001_010_100
  };

  state_t      state;
  logic [8:0]  sync1, sync2, prev;
  logic [8:0]  rise, occ, xs, os;
  logic [7:0]  line_x, line_o;
  logic [1:0]  code, win_code;
  logic [17:0] tiles_nxt;

  assign rise = sync2 & ~prev;
  assign code = turn ? 2'b01 : 2'b11;

  always_comb begin
    occ = '0;
    xs = '0;
    os = '0;
    tiles_nxt = tiles;
    for (int i = 0; i < 9; i++) begin
      occ[i] = |tiles[2*i +: 2];
      xs[i]  = tiles[2*i +: 2] == 2'b11;
      os[i]  = tiles[2*i +: 2] == 2'b01;
      if (rise[i]) tiles_nxt[2*i +: 2] = code;
    end
  end

  always_comb begin
    line_x = '0;
    line_o = '0;
    for (int l = 0; l < 8; l++) begin
      line_x[l] = (xs & LINE_MASK[l]) == LINE_MASK[l];
      line_o[l] = (os & LINE_MASK[l]) == LINE_MASK[l];
    end
    win_code = (|line_x) ? 2'b11 : (|line_o) ? 2'b01 : 2'b00;
  end

`ifdef WIN_MASK_EN
  logic [8:0] win_bits;
  always_comb begin
    win_bits = '0;
    for (int l = 0; l < 8; l++)
      if (line_x[l] || line_o[l]) win_bits = win_bits | LINE_MASK[l];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PLAY;
      sync1      <= '0;
      sync2      <= '0;
      prev       <= '0;
      tiles      <= '0;
      turn       <= 1'b0;
      winner     <= 2'b00;
      game_over  <= 1'b0;
      move_count <= '0;
      move_ok    <= 1'b0;
      move_err   <= 1'b0;
`ifdef WIN_MASK_EN
      win_mask   <= '0;
`endif
    end else begin
      sync1    <= input_switches;
      sync2    <= sync1;
      prev     <= sync2;
      move_ok  <= 1'b0;
      move_err <= 1'b0;
      unique case (state)
        PLAY: begin
          if (|rise) begin
            if ($onehot(rise) && !(|(rise & occ))) begin
              tiles      <= tiles_nxt;
              move_count <= move_count + 4'd1;
              move_ok    <= 1'b1;
              state      <= CHECK;
            end else begin
              move_err <= 1'b1;
            end
          end
        end
        CHECK: begin
          move_err <= |rise;
          if (win_code != 2'b00) begin
            winner    <= win_code;
            game_over <= 1'b1;
`ifdef WIN_MASK_EN
            win_mask  <= win_bits;
`endif
            state     <= OVER;
          end else if (move_count == 4'd9) begin
            winner    <= 2'b10;
            game_over <= 1'b1;
            state     <= OVER;
          end else begin
            turn  <= ~turn;
            state <= PLAY;
          end
        end
        OVER: move_err <= |rise;
        default: state <= PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_board_controller.sv
// Randomized bench for board_controller against a game-level reference model,
// plus directed games with hand-computed expectations.
module tb_board_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  sw;
  logic [17:0] tiles;
  logic        turn;
  logic [1:0]  winner;
  logic        game_over;
  logic [3:0]  move_count;
  logic        move_ok;
  logic        move_err;
`ifdef WIN_MASK_EN
  logic [8:0]  win_mask;
`endif

  board_controller dut (
    .clk(clk),
    .reset(reset),
    .input_switches(sw),
    .tiles(tiles),
    .turn(turn),
    .winner(winner),
    .game_over(game_over),
    .move_count(move_count),
    .move_ok(move_ok),
    .move_err(move_err)
`ifdef WIN_MASK_EN
    ,
    .win_mask(win_mask)
`endif
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      if (mismatched < 40)
        $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: game rules over a 9-entry board plus a switch delay line
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  int board [9];
  int m_turn, m_win, m_cnt, m_phase;
  int m_mask;
  bit m_ok, m_err, armed;
  logic [8:0] hist [3];

  function automatic logic [17:0] exp_tiles();
    logic [17:0] t;
    t = '0;
    for (int i = 0; i < 9; i++) t[2*i +: 2] = 2'(board[i]);
    return t;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      armed = 1;
      foreach (board[i]) board[i] = 0;
      m_turn = 0; m_win = 0; m_cnt = 0; m_phase = 0;
      m_mask = 0; m_ok = 0; m_err = 0;
      foreach (hist[i]) hist[i] = '0;
    end else begin
      logic [8:0] r;
      int n, sel;
      r = hist[1] & ~hist[2];
      n = $countones(r);
      sel = 0;
      for (int i = 0; i < 9; i++) if (r[i]) sel = i;
      m_ok = 0;
      m_err = 0;
      if (m_phase == 0) begin
        if (n == 1 && board[sel] == 0) begin
          board[sel] = m_turn ? 1 : 3;
          m_cnt++;
          m_ok = 1;
          m_phase = 1;
        end else if (n > 0) m_err = 1;
      end else if (m_phase == 1) begin
        m_err = n > 0;
        for (int l = 0; l < 8; l++) begin
          int a, b, c;
          a = board[lines[l][0]];
          b = board[lines[l][1]];
          c = board[lines[l][2]];
          if (a != 0 && a == b && b == c) begin
            m_win = a;
            for (int j = 0; j < 3; j++) m_mask |= 1 << lines[l][j];
          end
        end
        if (m_win != 0) m_phase = 2;
        else if (m_cnt == 9) begin m_win = 2; m_phase = 2; end
        else begin m_turn ^= 1; m_phase = 0; end
      end else begin
        m_err = n > 0;
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = sw;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("tiles", int'(tiles), int'(exp_tiles()));
      chk("turn", int'(turn), m_turn);
      chk("winner", int'(winner), m_win);
      chk("game_over", int'(game_over), int'(m_win != 0));
      chk("move_count", int'(move_count), m_cnt);
      chk("move_ok", int'(move_ok), int'(m_ok));
      chk("move_err", int'(move_err), int'(m_err));
`ifdef WIN_MASK_EN
      chk("win_mask", int'(win_mask), m_mask);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sw = '0;
    tick(2);
    reset = 1'b0;
  endtask

  logic        obs_ok, obs_err;
  logic [17:0] obs_tiles;

  // Raise mask, observe at edge k+2, drop, then let CHECK settle
  task automatic move(input logic [8:0] m);
    sw = m;
    tick(3);
    obs_ok = move_ok;
    obs_err = move_err;
    obs_tiles = tiles;
    sw = '0;
    tick(2);
  endtask

  initial begin
    reset = 1'b1;
    sw = '0;
    tick(2);
    chk("rst_tiles", int'(tiles), 0);
    chk("rst_count", int'(move_count), 0);
    reset = 1'b0;

    sw = 9'h001;
    tick(2);
    chk("s1_k1_tiles", int'(tiles), 0);
    tick(1);
    chk("s1_tiles", int'(tiles), 'h3);
    chk("s1_ok", int'(move_ok), 1);
    chk("s1_turn_k2", int'(turn), 0);
    sw = '0;
    tick(1);
    chk("s1_turn_k3", int'(turn), 1);
    tick(1);

    move(9'h002);
    chk("s2_tiles", int'(obs_tiles), 'h7);
    move(9'h001);
    chk("s2_err", int'(obs_err), 1);
    chk("s2_tiles_kept", int'(obs_tiles), 'h7);

    do_reset();
    move(9'h101);
    chk("s3_err", int'(obs_err), 1);
    chk("s3_ok", int'(obs_ok), 0);
    chk("s3_tiles", int'(obs_tiles), 0);
    chk("s3_count", int'(move_count), 0);

    do_reset();
    move(9'h001); move(9'h008); move(9'h002); move(9'h010); move(9'h004);
    chk("s4_winner", int'(winner), 3);
    chk("s4_over", int'(game_over), 1);
`ifdef WIN_MASK_EN
    chk("s4_mask", int'(win_mask), 'h007);
`endif
    move(9'h020);
    chk("s4_err", int'(obs_err), 1);
    chk("s4_tiles", int'(obs_tiles), 'h17F);

    do_reset();
    move(9'h001); move(9'h002); move(9'h004); move(9'h010); move(9'h008);
    move(9'h020); move(9'h080); move(9'h040); move(9'h100);
    chk("s5_count", int'(move_count), 9);
    chk("s5_winner", int'(winner), 2);
    chk("s5_over", int'(game_over), 1);
`ifdef WIN_MASK_EN
    chk("s5_mask", int'(win_mask), 0);
`endif

    reset = 1'b1;
    tick(1);
    chk("s6_tiles", int'(tiles), 0);
    chk("s6_winner", int'(winner), 0);
    chk("s6_over", int'(game_over), 0);
    chk("s6_count", int'(move_count), 0);
    chk("s6_turn", int'(turn), 0);
    reset = 1'b0;
    move(9'h010);
    chk("s6_newgame", int'(obs_tiles), 'h300);
    chk("s6_turn_after", int'(turn), 1);

    // Switch held high through reset release must register once
    reset = 1'b1;
    sw = 9'h040;
    tick(2);
    reset = 1'b0;
    tick(3);
    chk("s7_held_ok", int'(move_ok), 1);
    chk("s7_held_tiles", int'(tiles), 'h3000);
    sw = '0;
    tick(2);

    for (int c = 0; c < 4000; c++) begin
      int r;
      r = $urandom_range(0, 299);
      reset = (r == 0);
      if (r < 40) sw[$urandom_range(0, 8)] ^= 1'b1;
      else if (r < 44) sw = 9'($urandom);
      tick(1);
    end
    reset = 1'b0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
